sync_fifo_ram: RTL
==================

// Module: sync_fifo_ram
// PURPOSE
//  Parametrised single-clock FIFO built on a synchronous RAM array with read/write pointer counters.
//  Buffers DATA_WIDTH-bit words between producer and consumer stages of the datapath, e.g. memory-to-accumulator transfers.
//  Adds occupancy count, almost-full/almost-empty thresholds, registered read data with a valid strobe,
//  and sticky overflow/underflow error flags.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits
//  ADDR_WIDTH  4  pointer width; DEPTH = 2**ADDR_WIDTH entries
//  AF_MARGIN   1  oAlmostFull asserted when count >= DEPTH-AF_MARGIN
//  AE_MARGIN   1  oAlmostEmpty asserted when count <= AE_MARGIN
// PORTS
//  Clock         in   1             rising-edge clock
//  Reset         in   1             synchronous, active-high reset
//  iPush         in   1             write request
//  iData         in   DATA_WIDTH    write data, sampled when push is accepted
//  iPop          in   1             read request
//  oData         out  DATA_WIDTH    read data, registered
//  oValid        out  1             oData holds a newly popped word this cycle
//  oCount        out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//  oFull         out  1             oCount == DEPTH
//  oEmpty        out  1             oCount == 0
//  oAlmostFull   out  1             oCount >= DEPTH-AF_MARGIN
//  oAlmostEmpty  out  1             oCount <= AE_MARGIN
//  oOverflow     out  1             sticky: a push was rejected
//  oUnderflow    out  1             sticky: a pop was rejected
// BEHAVIOUR
//  - Reset (Clock edge with Reset=1):
//    - wr_ptr, rd_ptr, oCount, oData, oValid, oOverflow and oUnderflow all go to 0; oEmpty=1, oFull=0.
//    - RAM contents are not cleared.
//    - Reset overrides everything: push/pop in the reset cycle are dropped; a pending oValid is cleared.
//  - Accept rules, evaluated on the pre-edge oCount:
//    - push_ok = iPush & (~oFull | iPop)
//    - pop_ok  = iPop & ~oEmpty
//  - Push: RAM[wr_ptr] <= iData; wr_ptr += 1, wrapping modulo DEPTH.
//  - Pop: oData <= RAM[rd_ptr]; rd_ptr += 1, wrapping modulo DEPTH. oValid = pop_ok delayed one cycle (1-cycle read latency).
//    - When no pop is accepted, oData holds its previous value and oValid=0.
//  - oCount <= oCount + push_ok - pop_ok.
//  - Full, push+pop: both accepted, count unchanged. The read returns the oldest word, never the word being written.
//  - Empty, push+pop: push accepted, pop rejected, oUnderflow set. No write-to-read bypass.
//  - Push while full without pop: dropped, oOverflow <= 1. Pop while empty: oUnderflow <= 1.
//    - Both flags clear only on Reset.
//  - Status outputs are combinational decodes of the registered oCount and change only after a Clock edge.
//  - Widths: pointers are ADDR_WIDTH bits and oCount is ADDR_WIDTH+1 bits. Threshold compares are unsigned.
//    AF_MARGIN and AE_MARGIN must lie in 0..DEPTH.
// STRUCTURE
//  - No shared package entries are needed. DEPTH is a local constant derived from ADDR_WIDTH.
//  - One sub-module: ram_dual_port_sync (DATA_WIDTH, ADDR_WIDTH).
//    - One write port (iWE, iWAddr, iWData) and one registered read port (iRE, iRAddr, oRData), with no reset.
//    - On the same address, the read returns the old data.
//  - Pointers, count, valid and sticky flags live in the top level.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=2, AF_MARGIN=1, AE_MARGIN=1)
//  1. Push 0x11,0x22,0x33,0x44, then pop x4 -> oData 0x11,0x22,0x33,0x44 each one cycle after its pop, oValid=1 each;
//     oCount 4->0; oFull=1 at count 4, oEmpty=1 at end.
//  2. Fill with 4 words, push 0x55 without pop -> oCount stays 4, oOverflow=1; drain -> 0x55 never appears.
//  3. Full, push 0xAA + pop same cycle -> oCount stays 4, oData=oldest word; after draining, 0xAA is the last word out.
//  4. Empty, pop -> oValid stays 0, oUnderflow=1; then push 0x77 + pop same cycle -> oCount=1, oValid=0.
//  5. Push 6 / pop 6 interleaved across pointer wrap -> in-order data; oAlmostFull at count 3, oAlmostEmpty at count<=1.
//  6. Reset asserted with count 3 and a pop pending -> next cycle oCount=0, oValid=0, flags=0, oEmpty=1.

Source files
------------

// File: rtl/sync_fifo_ram_pkg.sv
// Shared helpers for the RAM-backed synchronous FIFO.
// The FIFO depth is derived here from the pointer width.
package sync_fifo_ram_pkg;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_dual_port_sync.sv
// Simple dual-port synchronous RAM: one write port and one registered read port.
// A read and a write to the same address in the same cycle return the old data.
module ram_dual_port_sync #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  Clock,
    input  logic                  iWE,
    input  logic [ADDR_WIDTH-1:0] iWAddr,
    input  logic [DATA_WIDTH-1:0] iWData,
    input  logic                  iRE,
    input  logic [ADDR_WIDTH-1:0] iRAddr,
    output logic [DATA_WIDTH-1:0] oRData
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge Clock) begin
        if (iWE) begin
            mem[iWAddr] <= iWData;
        end
        if (iRE) begin
            oRData <= mem[iRAddr];
        end
    end

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on a synchronous RAM with occupancy count, almost-full/empty
// thresholds, registered read data with a valid strobe and sticky error flags.
module sync_fifo_ram
    import sync_fifo_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_MARGIN  = 1,
    parameter int unsigned AE_MARGIN  = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iPush,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iPop,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oValid,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic                  oAlmostEmpty,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int unsigned         DEPTH      = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL   = (ADDR_WIDTH+1)'(AE_MARGIN);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  data_cleared;
    logic                  push_ok;
    logic                  pop_ok;

    always_comb begin
        oFull        = (count == FULL_LEVEL);
        oEmpty       = (count == '0);
        oAlmostFull  = (count >= AF_LEVEL);
        oAlmostEmpty = (count <= AE_LEVEL);
        push_ok      = iPush & (~oFull | iPop);
        pop_ok       = iPop & ~oEmpty;
    end

    ram_dual_port_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .Clock  (Clock),
        .iWE    (push_ok & ~Reset),
        .iWAddr (wr_ptr),
        .iWData (iData),
        .iRE    (pop_ok & ~Reset),
        .iRAddr (rd_ptr),
        .oRData (ram_rdata)
    );

    // The RAM read register has no reset; oData reads as zero until the first
    // accepted pop after reset, after which the RAM register itself holds the value.
    assign oData  = data_cleared ? '0 : ram_rdata;
    assign oCount = count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            oValid       <= 1'b0;
            oOverflow    <= 1'b0;
            oUnderflow   <= 1'b0;
            data_cleared <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr       <= rd_ptr + ADDR_WIDTH'(1);
                data_cleared <= 1'b0;
            end
            count  <= count + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
            oValid <= pop_ok;
            if (iPush && !push_ok) begin
                oOverflow <= 1'b1;
            end
            if (iPop && !pop_ok) begin
                oUnderflow <= 1'b1;
            end
        end
    end

endmodule
